// File: rtl/debounce_pulse.sv
// Button/switch conditioner: two-flop synchroniser, bounce qualification FSM,
// registered clean level and single-cycle rise/fall strobes.
module debounce_pulse #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_WIDTH     = 8
) (
    input  logic Clk,
    input  logic Reset,
    input  logic Din,
    output logic Q,
    output logic Rise,
    output logic Fall,
    output logic Busy
);

    typedef enum logic [1:0] {
        S_LOW,
        S_RISE_WAIT,
        S_HIGH,
        S_FALL_WAIT
    } state_t;

    localparam logic [CNT_WIDTH-1:0] STABLE = CNT_WIDTH'(STABLE_CYCLES);
    localparam logic [CNT_WIDTH-1:0] ONE    = CNT_WIDTH'(1);

    state_t               state;
    state_t               state_n;
    logic                 sync1;
    logic                 sync2;
    logic [CNT_WIDTH-1:0] cnt;
    logic [CNT_WIDTH-1:0] cnt_n;
    logic [CNT_WIDTH-1:0] cnt_inc;
    logic                 q_n;
    logic                 rise_n;
    logic                 fall_n;

    assign cnt_inc = cnt + ONE;
    assign Busy    = (state == S_RISE_WAIT) || (state == S_FALL_WAIT);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            state <= S_LOW;
            cnt   <= '0;
            Q     <= 1'b0;
            Rise  <= 1'b0;
            Fall  <= 1'b0;
        end else begin
            sync1 <= Din;
            sync2 <= sync1;
            state <= state_n;
            cnt   <= cnt_n;
            Q     <= q_n;
            Rise  <= rise_n;
            Fall  <= fall_n;
        end
    end

    // A single opposite sample while waiting aborts the qualification.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        q_n     = Q;
        rise_n  = 1'b0;
        fall_n  = 1'b0;
        case (state)
            S_LOW: begin
                if (sync2) begin
                    if (STABLE == ONE) begin
                        state_n = S_HIGH;
                        q_n     = 1'b1;
                        rise_n  = 1'b1;
                        cnt_n   = '0;
                    end else begin
                        state_n = S_RISE_WAIT;
                        cnt_n   = ONE;
                    end
                end
            end
            S_RISE_WAIT: begin
                if (!sync2) begin
                    state_n = S_LOW;
                    cnt_n   = '0;
                end else if (cnt_inc == STABLE) begin
                    state_n = S_HIGH;
                    q_n     = 1'b1;
                    rise_n  = 1'b1;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt_inc;
                end
            end
            S_HIGH: begin
                if (!sync2) begin
                    if (STABLE == ONE) begin
                        state_n = S_LOW;
                        q_n     = 1'b0;
                        fall_n  = 1'b1;
                        cnt_n   = '0;
                    end else begin
                        state_n = S_FALL_WAIT;
                        cnt_n   = ONE;
                    end
                end
            end
            S_FALL_WAIT: begin
                if (sync2) begin
                    state_n = S_HIGH;
                    cnt_n   = '0;
                end else if (cnt_inc == STABLE) begin
                    state_n = S_LOW;
                    q_n     = 1'b0;
                    fall_n  = 1'b1;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt_inc;
                end
            end
            default: begin
                state_n = S_LOW;
                cnt_n   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_debounce_pulse.sv
// Drives a STABLE_CYCLES=4 and a STABLE_CYCLES=1 debouncer with the same input
// and scores both against a run-length model of the synchronised input.
module tb_debounce_pulse;

    typedef struct packed {
        logic q;
        logic rise;
        logic fall;
        logic busy;
    } expect_t;

    logic Clk = 1'b0;
    logic Reset;
    logic Din;
    logic q4, rise4, fall4, busy4;
    logic q1, rise1, fall1, busy1;

    int testsRun  = 0;
    int failCount = 0;

    expect_t expQ[$];

    logic msync1 [2];
    logic msync2 [2];
    logic mq     [2];
    logic mrise  [2];
    logic mfall  [2];
    int   mrun   [2];

    always #5 Clk = ~Clk;

    debounce_pulse #(.STABLE_CYCLES(4), .CNT_WIDTH(8)) dut4 (
        .Clk(Clk), .Reset(Reset), .Din(Din),
        .Q(q4), .Rise(rise4), .Fall(fall4), .Busy(busy4)
    );

    debounce_pulse #(.STABLE_CYCLES(1), .CNT_WIDTH(8)) dut1 (
        .Clk(Clk), .Reset(Reset), .Din(Din),
        .Q(q1), .Rise(rise1), .Fall(fall1), .Busy(busy1)
    );

    // Output flips once the synchronised input has disagreed with it for
    // `stable` consecutive edges; Busy means a disagreement run is in progress.
    task automatic modelEdge(input int idx, input int stable, input logic din, input logic rst);
        expect_t e;
        if (rst) begin
            msync1[idx] = 1'b0;
            msync2[idx] = 1'b0;
            mq[idx]     = 1'b0;
            mrise[idx]  = 1'b0;
            mfall[idx]  = 1'b0;
            mrun[idx]   = 0;
        end else begin
            mrise[idx] = 1'b0;
            mfall[idx] = 1'b0;
            if (msync2[idx] != mq[idx]) begin
                mrun[idx] = mrun[idx] + 1;
                if (mrun[idx] == stable) begin
                    mq[idx]    = ~mq[idx];
                    mrise[idx] = mq[idx];
                    mfall[idx] = ~mq[idx];
                    mrun[idx]  = 0;
                end
            end else begin
                mrun[idx] = 0;
            end
            msync2[idx] = msync1[idx];
            msync1[idx] = din;
        end
        e.q    = mq[idx];
        e.rise = mrise[idx];
        e.fall = mfall[idx];
        e.busy = (mrun[idx] != 0);
        expQ.push_back(e);
    endtask

    task automatic checkBit(input string tag, input logic obs, input logic exp);
        testsRun++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s at %0t: observed %b expected %b", tag, $time, obs, exp);
        end
    endtask

    task automatic checkOutput();
        expect_t e4;
        expect_t e1;
        testsRun++;
        assert (expQ.size() >= 2) else begin
            failCount++;
            $error("[TB] FAIL scoreboard_underflow: observed %0d entries expected 2", expQ.size());
        end
        if (expQ.size() >= 2) begin
            e4 = expQ.pop_front();
            e1 = expQ.pop_front();
            checkBit("s4_q",    q4,    e4.q);
            checkBit("s4_rise", rise4, e4.rise);
            checkBit("s4_fall", fall4, e4.fall);
            checkBit("s4_busy", busy4, e4.busy);
            checkBit("s1_q",    q1,    e1.q);
            checkBit("s1_rise", rise1, e1.rise);
            checkBit("s1_fall", fall1, e1.fall);
            checkBit("s1_busy", busy1, e1.busy);
        end
    endtask

    task automatic applyStimulus(input logic din, input logic rst, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            Din   = din;
            Reset = rst;
            modelEdge(0, 4, din, rst);
            modelEdge(1, 1, din, rst);
            @(posedge Clk);
            @(negedge Clk);
            checkOutput();
        end
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            msync1[k] = 1'b0;
            msync2[k] = 1'b0;
            mq[k]     = 1'b0;
            mrise[k]  = 1'b0;
            mfall[k]  = 1'b0;
            mrun[k]   = 0;
        end
        Din   = 1'b0;
        Reset = 1'b1;

        // Reset with Din high, then release and qualify the held level
        applyStimulus(1'b1, 1'b1, 3);
        applyStimulus(1'b1, 1'b0, 10);
        applyStimulus(1'b0, 1'b0, 10);

        // Short glitch from low, then a clean press and release
        applyStimulus(1'b1, 1'b0, 3);
        applyStimulus(1'b0, 1'b0, 8);
        applyStimulus(1'b1, 1'b0, 20);
        applyStimulus(1'b0, 1'b0, 10);

        // Bouncing press settling high, then a held release
        applyStimulus(1'b1, 1'b0, 1);
        applyStimulus(1'b0, 1'b0, 1);
        applyStimulus(1'b1, 1'b0, 1);
        applyStimulus(1'b0, 1'b0, 1);
        applyStimulus(1'b1, 1'b0, 12);
        applyStimulus(1'b0, 1'b0, 12);

        // Reset while qualifying a press, then release with Din still high
        applyStimulus(1'b1, 1'b0, 3);
        applyStimulus(1'b1, 1'b1, 1);
        applyStimulus(1'b1, 1'b0, 10);

        // Glitch from high and reset while qualifying a release
        applyStimulus(1'b0, 1'b0, 3);
        applyStimulus(1'b1, 1'b0, 8);
        applyStimulus(1'b0, 1'b0, 3);
        applyStimulus(1'b0, 1'b1, 2);
        applyStimulus(1'b0, 1'b0, 6);

        for (int r = 0; r < 20; r++) begin
            applyStimulus(1'($urandom_range(0, 1)), 1'b0, $urandom_range(1, 7));
        end
        applyStimulus(1'b0, 1'b0, 8);

        testsRun++;
        assert (expQ.size() == 0) else begin
            failCount++;
            $error("[TB] FAIL scoreboard_leftover: observed %0d entries expected 0", expQ.size());
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule

// File: doc/debounce_pulse.md
Name: debounce_pulse

Overview:
- Front-end conditioning stage for board push-buttons and switches.
- Synchronises a raw asynchronous input to Clk and rejects contact bounce with a qualification counter.
- Emits a clean level plus single-cycle rise/fall strobes.
- Q drives the D input of the lab's D flip-flop and register stages; Rise/Fall serve as clock enables for those stages.

Parameters:
STABLE_CYCLES, 4, consecutive synchronised samples required to accept a new level; legal range 1..2^CNT_WIDTH-1 (board builds use ~500000).
CNT_WIDTH, 8, qualification counter width; must hold STABLE_CYCLES.

Ports:
Clk  input  1  system clock; all state updates on rising edge.
Reset  input  1  synchronous, active-high reset.
Din  input  1  raw asynchronous button/switch level.
Q  output  1  debounced level, registered.
Rise  output  1  one-cycle strobe when Q goes 0->1, registered.
Fall  output  1  one-cycle strobe when Q goes 1->0, registered.
Busy  output  1  high while a level change is being qualified; state decode.

Behaviour:
- Interface: one clock, Clk. Reset is synchronous and active-high; it is sampled only on a Clk rising edge.
- Reset:
  - Any edge with Reset=1 clears sync1, sync2, counter, state=S_LOW, Q=0, Rise=0, Fall=0.
  - Busy=0 after that edge. Din is ignored during reset.
- Synchroniser: sync1<=Din, sync2<=sync1 every edge. The FSM sees only sync2.
- States: S_LOW, S_RISE_WAIT, S_HIGH, S_FALL_WAIT. Busy=1 exactly in the two WAIT states.
- S_LOW:
  - sync2=1 and STABLE_CYCLES=1 -> S_HIGH, Q<=1, Rise<=1.
  - sync2=1 otherwise -> S_RISE_WAIT, cnt<=1.
  - sync2=0 -> stay.
- S_RISE_WAIT:
  - sync2=0 -> S_LOW, cnt<=0; glitch rejected, no strobe.
  - sync2=1 and cnt+1=STABLE_CYCLES -> S_HIGH, Q<=1, Rise<=1, cnt<=0.
  - Otherwise cnt<=cnt+1.
- S_HIGH and S_FALL_WAIT: mirror images of S_LOW and S_RISE_WAIT with sync2 inverted. They assert Fall and clear Q.
- Strobes:
  - Rise and Fall are high for exactly one cycle, the cycle after the accepting edge.
  - Both default to 0 on every other edge and are never high simultaneously.
- Latency: Din held at the new level from edge 0 gives the Q change after edge STABLE_CYCLES+1 (edge 0 is the first capture into sync1).
- Bounce: any opposite sample in a WAIT state aborts qualification. Counting restarts from 1 on the next new-level sample.
- Counter arithmetic:
  - Unsigned, CNT_WIDTH bits; never wraps because it is cleared at STABLE_CYCLES.
  - cnt is 0 in S_LOW and S_HIGH.
- Reset during a WAIT state: that edge forces S_LOW with no strobe. If Din is still high after release, a full new qualification and a Rise follow.

Test Plan:
- Reset: Din=1, Reset=1 for 3 edges -> Q=0, Rise=0, Fall=0, Busy=0. Release at edge 0 with Din=1 held -> Q=1 after edge 5; Rise=1 only in the cycle after edge 5.
- Clean press, STABLE_CYCLES=4: Din 0->1 before edge 0, held 20 cycles -> Busy=1 after edges 2, 3, 4; Q=1 after edge 5; exactly one Rise; no Fall.
- Glitch: from S_LOW, Din=1 for 3 cycles then 0 -> Q stays 0, no Rise, Busy returns to 0, cnt=0.
- Bounce then release:
  - Din toggles 1,0,1,0,1 one cycle each, then holds 1 -> exactly one Rise, 5 edges after the hold-1 sample reaches sync1.
  - Then Din=0 held -> Q=0 after a further 5 edges, with one Fall.
- Reset mid-qualification: Reset=1 at the edge after entering S_RISE_WAIT -> no Rise, Q=0, Busy=0. After release with Din=1 -> Rise 6 cycles later.
- STABLE_CYCLES=1 build: Din 0->1 at edge 0 -> Q=1 and Rise after edge 2; Busy never asserts.
